prio_encoder_arb: RTL

Parametrised, registered successor to the 8-to-3 priority encoder. Captures request pulses into a sticky pending vector and emits one encoded index per grant on a valid/ready output. Supports fixed priority (highest index wins) and round-robin modes. Sits between event sources (interrupt lines, channel requests) and a single serialising consumer.

---
 rtl/prio_encoder_arb_pkg.sv | 12 +
 rtl/prio_encoder_arb_if.sv | 34 +++
 rtl/prio_encoder_arb_pick.sv | 22 ++
 rtl/prio_encoder_arb.sv | 114 +++++++++++
 4 files changed

// File: rtl/prio_encoder_arb_pkg.sv
// Shared constants and helpers for the priority encoder / arbiter.
package prio_encoder_pkg;

    localparam int PRIO_FIXED = 0;
    localparam int PRIO_RR    = 1;

    // Index width for n request lines, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prio_encoder_arb_if.sv
// Request/grant bundle between event sources, the arbiter and its consumer.
interface prio_encoder_arb_if
    import prio_encoder_pkg::*;
#(
    parameter int N = 8,
    parameter int W = clog2_min1(N)
);
    logic [N-1:0] req_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic [N-1:0] pending;
    logic         busy;

    // Arbiter side.
    modport master (
        input  req_in,
        input  out_ready,
        output out_valid,
        output out_idx,
        output pending,
        output busy
    );

    // Sources and consumer side.
    modport slave (
        output req_in,
        output out_ready,
        input  out_valid,
        input  out_idx,
        input  pending,
        input  busy
    );
endinterface

// File: rtl/prio_encoder_arb_pick.sv
// Combinational highest-set-bit finder.
module prio_pick
    import prio_encoder_pkg::*;
#(
    parameter int N = 8,
    parameter int W = clog2_min1(N)
) (
    input  logic [N-1:0] vec_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    // Ascending scan so the last (highest) set bit wins.
    always_comb begin
        idx_o   = '0;
        found_o = |vec_i;
        for (int i = 0; i < N; i++) begin
            if (vec_i[i]) idx_o = W'(i);
        end
    end

endmodule

// File: rtl/prio_encoder_arb.sv
// Registered priority encoder / arbiter: sticky pending vector feeding a
// one-entry valid/ready output stage, fixed or round-robin priority.
module prio_encoder_arb
    import prio_encoder_pkg::*;
#(
    parameter int N    = 8,
    parameter int MODE = PRIO_FIXED
) (
    input  logic              clk,
    input  logic              rst_n,
    prio_encoder_arb_if.master bus
);

    localparam int W = clog2_min1(N);

    logic [N-1:0] pending_q, pending_d;
    logic         valid_q, valid_d;
    logic [W-1:0] idx_q, idx_d;

    logic [N-1:0] cand;
    logic [N-1:0] sel_clr;
    logic [W-1:0] sel;
    logic         load;

    assign cand = pending_q | bus.req_in;
    assign load = (!valid_q || bus.out_ready) && (cand != '0);

    generate
        if (MODE == PRIO_RR) begin : g_rr
            logic [W-1:0] rr_q;
            logic [N-1:0] mask;
            logic [W-1:0] idx_lo, idx_all;
            logic         found_lo, found_all;

            // Restrict the first search to indices strictly below the last grant.
            always_comb begin
                mask = '0;
                for (int i = 0; i < N; i++) begin
                    mask[i] = (i < int'(rr_q));
                end
            end

            prio_pick #(.N(N), .W(W)) u_pick_lo (
                .vec_i   (cand & mask),
                .idx_o   (idx_lo),
                .found_o (found_lo)
            );

            prio_pick #(.N(N), .W(W)) u_pick_all (
                .vec_i   (cand),
                .idx_o   (idx_all),
                .found_o (found_all)
            );

            // Wrap to the unmasked search when nothing lies below the pointer.
            assign sel = found_lo ? idx_lo : idx_all;

            // Pointer follows each grant; reset value 0 mimics fixed priority.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)    rr_q <= '0;
                else if (load) rr_q <= sel;
            end
        end else begin : g_fix
            logic found_unused;

            prio_pick #(.N(N), .W(W)) u_pick (
                .vec_i   (cand),
                .idx_o   (sel),
                .found_o (found_unused)
            );
        end
    endgenerate

    // One-hot of the selected index, removed from pending on a load.
    always_comb begin
        sel_clr = '0;
        for (int i = 0; i < N; i++) begin
            sel_clr[i] = (int'(sel) == i);
        end
    end

    // Next state: load a new grant, retire an accepted one, or hold and absorb.
    always_comb begin
        pending_d = cand;
        valid_d   = valid_q;
        idx_d     = idx_q;
        if (load) begin
            pending_d = cand & ~sel_clr;
            valid_d   = 1'b1;
            idx_d     = sel;
        end else if (valid_q && bus.out_ready) begin
            valid_d   = 1'b0;
        end
    end

    // State registers; reset drops any in-flight grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
        end else begin
            pending_q <= pending_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_idx   = idx_q;
    assign bus.pending   = pending_q;
    assign bus.busy      = valid_q | (|pending_q);

endmodule
